grey_scan_display: RTL
======================

Name: grey_scan_display

Overview:
- Downstream consumer of the 12-digit grey-code decade counter.
- Takes the counter's 60-bit bus of 5-bit digit codes and drives a time-multiplexed 7-segment display, one digit at a time.
- Takes a coherent per-frame snapshot, blanks leading zeros, inserts thousands separators, and flags illegal digit codes.

Parameters:
- DIGITS, 12: number of digits scanned. The input bus is 5*DIGITS bits wide.
- PRESCALE, 1024: i_clk cycles per digit slot. Must be 2 or more.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_digits  in  5*DIGITS  digit codes. Digit k is at [5k+4:5k]; digit 0 = ones, digit DIGITS-1 = most significant.
- i_en  in  1  scan enable.
- i_blank_lz  in  1  enable leading-zero blanking.
- i_sep  in  1  enable the decimal point on digits 3, 6 and 9.
- o_seg  out  7  segments gfedcba, active-high, registered.
- o_dp  out  1  decimal point, registered.
- o_digit  out  4  index of the digit currently driven, registered.
- o_frame  out  1  one-cycle pulse when a new frame starts (MSD slot).
- o_err  out  1  sticky illegal-code flag.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous, active-high, and overrides everything.
- Reset values:
  - prescaler = 0, index = 0, lz_flag = 0.
  - shadow = all ZERO codes (5'b10001 per digit).
  - o_seg = 0, o_dp = 0, o_digit = 0, o_frame = 0, o_err = 0.
- Code map (code -> digit -> seg hex):
  - 10001->0->3F, 00001->1->06, 00011->2->5B, 00010->3->4F, 00110->4->66
  - 00100->5->6D, 01100->6->7D, 01000->7->07, 11000->8->7F, 10000->9->6F
  - Any other code is illegal and displays "E" = 79.
- Prescaler:
  - Counts 0..PRESCALE-1 while i_en = 1.
  - tick = (prescaler == PRESCALE-1) && i_en. On tick the prescaler returns to 0.
- Index, scanned MSD to LSD. On tick:
  - If index == 0: index <= DIGITS-1; shadow <= i_digits; lz_flag <= i_blank_lz; o_frame <= 1.
  - Otherwise: index <= index-1.
  - The first tick after reset therefore starts a frame.
- Output timing:
  - On tick, o_digit, o_seg and o_dp all load values for the new index in the same cycle.
  - On the frame-start tick, the MSD is decoded from live i_digits, which is identical to the value being captured into shadow.
  - Every other slot decodes from shadow.
  - Between ticks, outputs hold.
  - o_frame is 1 only in the cycle after a frame-start tick.
- Frame coherence: i_digits changes during a frame are not displayed until the next frame.
- Leading-zero blanking, evaluated per slot with d = the decoded digit:
  - If lz_flag = 1, d is ZERO and index != 0: the slot is blanked (o_seg = 0, o_dp = 0) and lz_flag stays 1.
  - Otherwise lz_flag <= 0 and the slot is displayed normally.
  - Illegal codes count as non-zero and clear lz_flag.
  - Digit 0 is never blanked.
- Decimal point: o_dp = i_sep && (index is 3, 6 or 9) && slot not blanked. Indices beyond DIGITS-1 never occur.
- Errors:
  - Any slot that decodes an illegal code sets o_err.
  - o_err is cleared only by i_rst.
  - o_err is set in the same cycle that o_seg shows 79.
- Enable:
  - While i_en = 0: prescaler, index, shadow and lz_flag hold; o_seg = 0, o_dp = 0, o_frame = 0; o_digit holds.
  - When i_en returns to 1, the held slot's segments are re-driven on the next cycle. Its lz outcome is reused, not re-evaluated.
  - Scanning then continues from the held prescaler count.
- Reset mid-frame: takes effect on the next edge regardless of prescaler state. The scan restarts at the next tick.

Test Plan (PRESCALE=4, DIGITS=12; frame = 48 cycles):
- Reset, i_digits all 10001, i_blank_lz=1, i_en=1 -> o_frame pulses every 48 cycles; o_seg=00 for indices 11..1; o_seg=3F at index 0; o_err=0.
- i_digits = 000000001205 in grey code, i_blank_lz=1, i_sep=1:
  - indices 11..4 -> 00
  - index 3 -> 06 with o_dp=1
  - index 2 -> 5B, index 1 -> 3F, index 0 -> 6D
  - o_dp=0 at indices 9 and 6 because those slots are blanked.
- Same value with i_blank_lz=0 -> indices 11..4 show 3F; o_dp=1 at indices 9, 6 and 3.
- Change i_digits from ...1205 to ...9999 while index 5 is displayed -> remaining slots of the frame still show 06,5B,3F,6D; the next frame shows 6F at indices 3..0.
- Code 5'b00000 at digit 7, all other digits ZERO, lz enabled -> index 7 shows 79 and o_err=1 from that cycle; indices 6..0 show 3F; o_err stays 1 after the code is corrected.
- Drop i_en for 10 cycles at index 4 -> o_seg=00 and o_digit=4 held; resumes at index 4 and then proceeds to index 3 after the remaining prescaler count. Assert i_rst mid-frame -> all outputs 0 next cycle, o_err cleared.

Source files
------------

// File: rtl/grey_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : grey_scan_display
// Purpose  : Time-multiplexed 7-segment scanner for a grey-coded decade bus,
//            with per-frame snapshot, leading-zero blanking and error flag.
// Revision : 1.0 - initial release
// ============================================================================
module grey_scan_display #(
    parameter int DIGITS   = 12,
    parameter int PRESCALE = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [5*DIGITS-1:0]   i_digits,
    input  logic                  i_en,
    input  logic                  i_blank_lz,
    input  logic                  i_sep,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [3:0]            o_digit,
    output logic                  o_frame,
    output logic                  o_err
);

    localparam int              PW          = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   c_PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [3:0]      c_MSD       = 4'(DIGITS - 1);
    localparam logic [4:0]      c_ZERO      = 5'b10001;

    logic [PW-1:0]              r_presc;
    logic [3:0]                 r_index;
    logic [DIGITS-1:0][4:0]     r_shadow;
    logic                       r_lz;
    logic [6:0]                 r_seg;
    logic                       r_dp;
    logic                       r_frame;
    logic                       r_err;
    logic [6:0]                 r_slot_seg;
    logic                       r_slot_dp;

    logic                       w_tick;
    logic                       w_wrap;
    logic [3:0]                 w_next_idx;
    logic [4:0]                 w_code;
    logic                       w_lz_in;
    logic [6:0]                 w_dseg;
    logic                       w_illegal;
    logic                       w_blank;
    logic                       w_sep_pos;
    logic [6:0]                 w_new_seg;
    logic                       w_new_dp;

    assign w_tick     = i_en && (r_presc == c_PRESC_MAX);
    assign w_wrap     = (r_index == 4'd0);
    assign w_next_idx = w_wrap ? c_MSD : (r_index - 4'd1);

    // The frame-start slot reads the live bus, which is what the shadow captures on that same edge.
    assign w_code     = w_wrap ? i_digits[5*DIGITS-1 -: 5] : r_shadow[w_next_idx];
    assign w_lz_in    = w_wrap ? i_blank_lz : r_lz;

    always_comb begin
        w_dseg    = 7'h79;
        w_illegal = 1'b0;
        case (w_code)
            5'b10001: w_dseg = 7'h3F;
            5'b00001: w_dseg = 7'h06;
            5'b00011: w_dseg = 7'h5B;
            5'b00010: w_dseg = 7'h4F;
            5'b00110: w_dseg = 7'h66;
            5'b00100: w_dseg = 7'h6D;
            5'b01100: w_dseg = 7'h7D;
            5'b01000: w_dseg = 7'h07;
            5'b11000: w_dseg = 7'h7F;
            5'b10000: w_dseg = 7'h6F;
            default: begin
                w_dseg    = 7'h79;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_blank   = w_lz_in && (w_code == c_ZERO) && (w_next_idx != 4'd0);
    assign w_sep_pos = (w_next_idx == 4'd3) || (w_next_idx == 4'd6) || (w_next_idx == 4'd9);
    assign w_new_seg = w_blank ? 7'h00 : w_dseg;
    assign w_new_dp  = i_sep && w_sep_pos && !w_blank;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc    <= '0;
            r_index    <= 4'd0;
            r_shadow   <= {DIGITS{c_ZERO}};
            r_lz       <= 1'b0;
            r_seg      <= 7'h00;
            r_dp       <= 1'b0;
            r_frame    <= 1'b0;
            r_err      <= 1'b0;
            r_slot_seg <= 7'h00;
            r_slot_dp  <= 1'b0;
        end else begin
            r_frame <= w_tick && w_wrap;
            if (i_en) begin
                r_presc <= w_tick ? '0 : (r_presc + 1'b1);
            end
            if (w_tick) begin
                r_index    <= w_next_idx;
                // Blanking can only be true when the incoming flag was set, so it doubles as the new flag.
                r_lz       <= w_blank;
                r_slot_seg <= w_new_seg;
                r_slot_dp  <= w_new_dp;
                r_seg      <= w_new_seg;
                r_dp       <= w_new_dp;
                if (w_wrap) begin
                    r_shadow <= i_digits;
                end
                if (w_illegal) begin
                    r_err <= 1'b1;
                end
            end else if (!i_en) begin
                r_seg <= 7'h00;
                r_dp  <= 1'b0;
            end else begin
                // Re-drive the held slot after an enable gap without re-evaluating it.
                r_seg <= r_slot_seg;
                r_dp  <= r_slot_dp;
            end
        end
    end

    assign o_seg   = r_seg;
    assign o_dp    = r_dp;
    assign o_digit = r_index;
    assign o_frame = r_frame;
    assign o_err   = r_err;

endmodule
`default_nettype wire
